// File: rtl/io_load_response_queue_if.sv
// Bundles the EX request, data-RAM response, flush and WB result signals of io_load_response_queue.
// master = surrounding pipeline (EX / data RAM / WB), slave = the queue itself.
interface io_load_response_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic                           req_valid;
    logic                           req_ready;
    logic [2:0]                     req_kind;
    logic                           req_unsigned;
    logic [1:0]                     req_offset;
    logic                           resp_valid;
    logic [DATA_WIDTH-1:0]          resp_data;
    logic                           flush;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [DATA_WIDTH/8-1:0]        out_strobe;
    logic [$clog2(DEPTH+1)-1:0]     pending_count;
    logic                           resp_error;

    modport master (
        output req_valid, req_kind, req_unsigned, req_offset,
        output resp_valid, resp_data, flush, out_ready,
        input  req_ready, out_valid, out_data, out_strobe, pending_count, resp_error
    );

    modport slave (
        input  req_valid, req_kind, req_unsigned, req_offset,
        input  resp_valid, resp_data, flush, out_ready,
        output req_ready, out_valid, out_data, out_strobe, pending_count, resp_error
    );
endinterface

// File: rtl/io_load_response_queue.sv
// In-order load response queue: tracks DEPTH outstanding data-RAM requests and hands aligned loads to WB.
// Define IO_LOAD_LEFT_RIGHT_EN to enable LWL/LWR merging; otherwise kinds 3/4 behave as LW.
module io_load_response_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic                     clock,
    input logic                     reset,
    io_load_response_queue_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [2:0] KIND_LB    = 3'd0;
    localparam logic [2:0] KIND_LH    = 3'd1;
    localparam logic [2:0] KIND_STORE = 3'd7;
`ifdef IO_LOAD_LEFT_RIGHT_EN
    localparam logic [2:0] KIND_LWL   = 3'd3;
    localparam logic [2:0] KIND_LWR   = 3'd4;
`endif

    // Slot control (reset) and payload (not reset).
    logic [1:0]            state   [DEPTH];
    logic [DEPTH-1:0]      discard;
    logic [DEPTH-1:0]      silent;
    logic [2:0]            kind_q  [DEPTH];
    logic [DEPTH-1:0]      uns_q;
    logic [1:0]            off_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [NB-1:0]         strb_q  [DEPTH];

    logic [PW-1:0] alloc_ptr, resp_ptr, retire_ptr;
    logic [CW-1:0] count;
    logic          resp_error_q;

    logic          accept, resp_hit, head_done, retire, out_valid;
    logic [CW-1:0] done_count, flushed_count;

    // Returns {aligned_data, strobe} for a load response.
    function automatic logic [DATA_WIDTH+NB-1:0] align(
        input logic [2:0]            kind,
        input logic                  uns,
        input logic [1:0]            off,
        input logic [DATA_WIDTH-1:0] d
    );
        logic [DATA_WIDTH-1:0] bsh, hsh, r;
        logic [NB-1:0]         s;
        bsh = d >> {off, 3'b000};
        hsh = d >> {off[1], 4'b0000};
        r   = d;
        s   = '1;
        case (kind)
            KIND_LB: r = uns ? DATA_WIDTH'(bsh[7:0])  : {{(DATA_WIDTH-8){bsh[7]}}, bsh[7:0]};
            KIND_LH: r = uns ? DATA_WIDTH'(hsh[15:0]) : {{(DATA_WIDTH-16){hsh[15]}}, hsh[15:0]};
`ifdef IO_LOAD_LEFT_RIGHT_EN
            KIND_LWL: begin
                r = d << {2'd3 - off, 3'b000};
                s = {NB{1'b1}} << (2'd3 - off);
            end
            KIND_LWR: begin
                r = d >> {off, 3'b000};
                s = {NB{1'b1}} >> off;
            end
`endif
            default: ;
        endcase
        return {r, s};
    endfunction

    assign accept    = bus.req_valid & bus.req_ready;
    assign resp_hit  = bus.resp_valid & (state[resp_ptr] == ST_PENDING);
    assign head_done = state[retire_ptr] == ST_DONE;
    assign retire    = ~bus.flush & head_done & (silent[retire_ptr] | bus.out_ready);
    assign out_valid = ~bus.flush & head_done & ~silent[retire_ptr];

    assign bus.req_ready     = (count != FULL) & ~bus.flush;
    assign bus.out_valid     = out_valid;
    assign bus.out_data      = out_valid ? data_q[retire_ptr] : '0;
    assign bus.out_strobe    = out_valid ? strb_q[retire_ptr] : '0;
    assign bus.pending_count = count;
    assign bus.resp_error    = resp_error_q;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        done_count = '0;
        for (int i = 0; i < DEPTH; i++)
            if (state[i] == ST_DONE) done_count = done_count + CW'(1);
        flushed_count = bus.flush ? done_count : '0;
    end

    // NOTE: state registers use non-blocking assignments so every read in this block sees the pre-edge value.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) state[i] <= ST_FREE;
            discard      <= '0;
            silent       <= '0;
            alloc_ptr    <= '0;
            resp_ptr     <= '0;
            retire_ptr   <= '0;
            count        <= '0;
            resp_error_q <= 1'b0;
        end else begin
            // Flush frees every responded slot and marks in-flight ones so their data is dropped.
            if (bus.flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (state[i] == ST_DONE)    state[i]   <= ST_FREE;
                    if (state[i] == ST_PENDING) discard[i] <= 1'b1;
                end
            end

            if (accept) begin
                state[alloc_ptr]   <= ST_PENDING;
                discard[alloc_ptr] <= 1'b0;
                alloc_ptr          <= alloc_ptr + PW'(1);
            end

            if (resp_hit) begin
                state[resp_ptr]  <= ST_DONE;
                silent[resp_ptr] <= (kind_q[resp_ptr] == KIND_STORE) | discard[resp_ptr] | bus.flush;
                resp_ptr         <= resp_ptr + PW'(1);
            end else if (bus.resp_valid) begin
                resp_error_q <= 1'b1;
            end

            if (bus.flush) begin
                retire_ptr <= resp_ptr;
            end else if (retire) begin
                state[retire_ptr] <= ST_FREE;
                retire_ptr        <= retire_ptr + PW'(1);
            end

            count <= count + CW'(accept) - CW'(retire) - flushed_count;
        end
    end

    // NOTE: payload storage is deliberately not reset; it is only read while the slot state marks it live.
    always_ff @(posedge clock) begin
        if (accept) begin
            kind_q[alloc_ptr] <= bus.req_kind;
            uns_q[alloc_ptr]  <= bus.req_unsigned;
            off_q[alloc_ptr]  <= bus.req_offset;
        end
        if (resp_hit)
            {data_q[resp_ptr], strb_q[resp_ptr]} <=
                align(kind_q[resp_ptr], uns_q[resp_ptr], off_q[resp_ptr], bus.resp_data);
    end
endmodule

// File: tb/tb_io_load_response_queue.sv
// Randomized scoreboard bench for io_load_response_queue against a queue-level reference model.
module tb_io_load_response_queue;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_load_response_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
    io_load_response_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] kind;
        logic       uns;
        logic [1:0] off;
        logic       responded;
        logic       silent;
        logic       discard;
    } ent_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } res_t;

    ent_t mq[$];
    res_t sb[$];
    logic merr;
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_out    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Load result computed from byte lanes and signed arithmetic.
    function automatic res_t ref_load(input logic [2:0] kind, input logic uns,
                                      input logic [1:0] off, input logic [31:0] d);
        res_t        r;
        logic [7:0]  lane [4];
        logic [15:0] h;
        int          o;
        o = int'(off);
        for (int i = 0; i < 4; i++) lane[i] = d[8*i +: 8];
        r.data = d;
        r.strb = 4'hF;
        case (kind)
            3'd0: r.data = uns ? {24'h0, lane[o]} : 32'($signed(lane[o]));
            3'd1: begin
                h = off[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};
                r.data = uns ? {16'h0, h} : 32'($signed(h));
            end
`ifdef IO_LOAD_LEFT_RIGHT_EN
            3'd3: begin
                r.data = d << (8 * (3 - o));
                for (int j = 0; j < 4; j++) r.strb[j] = (j >= 3 - o);
            end
            3'd4: begin
                r.data = d >> (8 * o);
                for (int j = 0; j < 4; j++) r.strb[j] = (j <= 3 - o);
            end
`endif
            default: ;
        endcase
        return r;
    endfunction

    function automatic int first_unresp();
        for (int i = 0; i < mq.size(); i++)
            if (!mq[i].responded) return i;
        return -1;
    endfunction

    // One clock of stimulus: drive, check status at negedge, advance the model at posedge.
    task automatic step(input logic rv, input logic [2:0] k, input logic u, input logic [1:0] o,
                        input logic pv, input logic [31:0] pd, input logic fl, input logic ordy);
        logic acc, ret, exp_ov;
        int   idx;
        ent_t e;
        bus.req_valid    = rv;
        bus.req_kind     = k;
        bus.req_unsigned = u;
        bus.req_offset   = o;
        bus.resp_valid   = pv;
        bus.resp_data    = pd;
        bus.flush        = fl;
        bus.out_ready    = ordy;
        @(negedge clk);
        exp_ov = !fl && mq.size() > 0 && mq[0].responded && !mq[0].silent;
        check("req_ready", 64'(bus.req_ready), 64'((mq.size() != DEPTH) && !fl));
        check("pending_count", 64'(bus.pending_count), 64'(mq.size()));
        check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
        check("resp_error", 64'(bus.resp_error), 64'(merr));
        @(posedge clk);
        acc = rv && (mq.size() != DEPTH) && !fl;
        ret = !fl && mq.size() > 0 && mq[0].responded && (mq[0].silent || ordy);
        if (fl) begin
            sb.delete();
            for (int i = 0; i < mq.size(); i++)
                if (!mq[i].responded) mq[i].discard = 1'b1;
            while (mq.size() > 0 && mq[0].responded) void'(mq.pop_front());
        end
        if (pv) begin
            idx = first_unresp();
            if (idx < 0) begin
                merr = 1'b1;
            end else begin
                mq[idx].responded = 1'b1;
                mq[idx].silent    = (mq[idx].kind == 3'd7) || mq[idx].discard || fl;
                if (!mq[idx].silent)
                    sb.push_back(ref_load(mq[idx].kind, mq[idx].uns, mq[idx].off, pd));
            end
        end
        if (ret) void'(mq.pop_front());
        if (acc) begin
            e = '{kind: k, uns: u, off: o, responded: 1'b0, silent: 1'b0, discard: 1'b0};
            mq.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, ordy);
    endtask

    task automatic expect_out(input string name, input logic [31:0] d, input logic [3:0] s);
        check({name, "_valid"}, 64'(bus.out_valid), 64'(1));
        check({name, "_data"}, 64'(bus.out_data), 64'(d));
        check({name, "_strobe"}, 64'(bus.out_strobe), 64'(s));
    endtask

    // Answers outstanding requests and accepts results until the model is empty (bounded).
    task automatic drain(input string name);
        for (int n = 0; n < 40 && mq.size() > 0; n++)
            step(1'b0, 3'd0, 1'b0, 2'd0, first_unresp() >= 0, $urandom, 1'b0, 1'b1);
        check({name, "_drained"}, 64'(bus.pending_count), 64'(0));
    endtask

    // Monitor: a result leaves on every out_valid & out_ready and must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_output: got data %0h, expected no output at %0t", bus.out_data, $time);
            end else begin
                res_t r;
                r = sb.pop_front();
                check("out_data", 64'(bus.out_data), 64'(r.data));
                check("out_strobe", 64'(bus.out_strobe), 64'(r.strb));
            end
        end
    end

    initial begin
        int n0;
        logic pv;
        rst              = 1'b1;
        merr             = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_kind     = 3'd0;
        bus.req_unsigned = 1'b0;
        bus.req_offset   = 2'd0;
        bus.resp_valid   = 1'b0;
        bus.resp_data    = '0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_count", 64'(bus.pending_count), 64'(0));
        check("rst_req_ready", 64'(bus.req_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_resp_error", 64'(bus.resp_error), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_out_strobe", 64'(bus.out_strobe), 64'(0));

        // LB offset 3 signed
        step(1'b1, 3'd0, 1'b0, 2'd3, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 32'h80FF_0000, 1'b0, 1'b1);
        expect_out("lb_off3", 32'hFFFF_FF80, 4'hF);
        idle(1'b1);

        // LH offset 2 unsigned
        step(1'b1, 3'd1, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 32'hBEEF_1234, 1'b0, 1'b1);
        expect_out("lhu_off2", 32'h0000_BEEF, 4'hF);
        idle(1'b1);

        // Fill, respond with WB stalled, then release
        for (int i = 0; i < DEPTH; i++) step(1'b1, 3'd2, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("full_req_ready", 64'(bus.req_ready), 64'(0));
        for (int i = 0; i < DEPTH; i++) step(1'b0, 3'd0, 1'b0, 2'd0, 1'b1, $urandom, 1'b0, 1'b0);
        repeat (3) idle(1'b0);
        check("held_out_valid", 64'(bus.out_valid), 64'(1));
        check("held_count", 64'(bus.pending_count), 64'(DEPTH));
        drain("full");

        // Flush with two loads pending; a request right after flush is accepted
        repeat (2) step(1'b1, 3'd2, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 3'd0, 1'b1, 2'd1, 1'b1, $urandom, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 2'd0, 1'b1, $urandom, 1'b0, 1'b1);
        drain("flush");

        // Store followed by load: only the load produces a result
        n0 = n_out;
        step(1'b1, 3'd7, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 3'd2, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 32'h1111_2222, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 32'h3333_4444, 1'b0, 1'b1);
        drain("store_load");
        check("store_load_outputs", 64'(n_out - n0), 64'(1));

`ifdef IO_LOAD_LEFT_RIGHT_EN
        step(1'b1, 3'd3, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 32'h1122_3344, 1'b0, 1'b1);
        expect_out("lwl_off1", 32'h3344_0000, 4'b1100);
        idle(1'b1);
`endif

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            pv = (first_unresp() >= 0) && ($urandom_range(0, 2) != 0);
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), pv, $urandom, ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        drain("random");

        // Response with nothing pending sets a sticky error
        step(1'b0, 3'd0, 1'b0, 2'd0, 1'b1, $urandom, 1'b0, 1'b1);
        check("resp_error_set", 64'(bus.resp_error), 64'(1));
        repeat (3) idle(1'b1);
        check("resp_error_sticky", 64'(bus.resp_error), 64'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
